cp0_ctrl_v2: RTL
================

Name: cp0_ctrl_v2

Overview:
- Parametrised second-generation coprocessor 0, tightly coupled to the pipeline's exception stage.
- Adds the following over the first generation:
  - internally generated timer interrupt
  - a configurable number of hardware interrupt lines
  - interrupt-request qualification (IE, EXL, IM)
  - branch-delay-slot EPC correction
  - BEV boot vector
  - optional vectored interrupt dispatch
- Owns Status, Cause, EPC, BadVAddr, Count, Compare and EBase; produces the redirect target on exception entry and on ERET.

Parameters:
- NR_HW_INT, 5: hardware interrupt lines mapped to Cause.IP[2+NR_HW_INT-1:2]; legal range 1..5.
- EBASE_RESET, 32'h80000000: EBase value after reset.
- BEV_BASE, 32'hBFC00200: vector base used while Status.BEV=1.
- VECTORED, 1: 1 enables vectored interrupt dispatch when Cause.IV=1.
- VEC_SPACING, 32: byte spacing between interrupt vectors; must be a power of 2, 32..512.
- COUNT_DIV, 1: Count increments once every COUNT_DIV clocks; legal range 1..256.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rd_addr  in  5  CP0 register number to read
- rd_data  out  32  combinational read of current register value; unimplemented numbers read 0
- wr_en  in  1  register write strobe
- wr_addr  in  5  register number to write
- wr_data  in  32  write data
- exc_valid  in  1  take an exception this cycle
- exc_code  in  5  ExcCode; 0 means interrupt
- exc_epc  in  32  PC of the faulting or interrupted instruction
- exc_bd  in  1  faulting instruction is in a branch delay slot
- exc_badvaddr  in  32  faulting address
- eret  in  1  execute ERET
- hw_int  in  NR_HW_INT  level-sensitive interrupt lines, already synchronised
- int_req  out  1  interrupt pending and enabled
- timer_irq  out  1  timer interrupt level, equal to Cause.IP[7]
- exc_jmp_flag  out  1  one-cycle redirect pulse
- exc_jmp_dest  out  32  redirect target, valid while exc_jmp_flag=1

Behaviour:
- Register numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, EBase 15.
- Reset state:
  - EBase = EBASE_RESET; every other register 0; Status.BEV = 0.
  - timer_irq = 0, exc_jmp_flag = 0, exc_jmp_dest = 0.
  - Count prescaler cleared.
  - rst dominates every other input in the same cycle.
- Writable fields:
  - Status: IM[15:8], BEV[22], EXL[1], IE[0]; all other Status bits read 0.
  - Cause: software IP[9:8] and IV[23] only.
  - EBase: bits [29:12] only; [31:30] always read 2'b10, [11:0] always read 0.
  - Count, Compare and EPC are fully writable.
  - BadVAddr is read-only.
- Cause.IP[6:2]: hw_int registered one clock, so it lags the pins by 1 cycle. Bits beyond NR_HW_INT read 0. Cause.IP[7] = timer_irq.
- Count:
  - Increments by 1 every COUNT_DIV clocks and wraps at 2^32.
  - A Count write takes priority over the increment and also clears the prescaler.
- Timer:
  - When registered Count equals registered Compare and no Compare write occurs that cycle, timer_irq is set on the next posedge.
  - timer_irq is sticky and is cleared only by a Compare write.
  - If a compare match and a Compare write occur in the same cycle, the clear wins.
- int_req = IE & ~EXL & |(Cause.IP[7:0] & Status.IM). It is combinational from registers only; inputs do not affect it in the same cycle.
- Per-cycle priority: exc_valid > eret > wr_en. A lower-priority action in the same cycle is dropped entirely. Count increment and the timer update proceed regardless.
- Exception entry, EXL=0:
  - EPC <= exc_bd ? exc_epc-4 : exc_epc.
  - Cause.BD[31] <= exc_bd; Cause.ExcCode[6:2] <= exc_code; EXL <= 1.
  - BadVAddr <= exc_badvaddr only when exc_code is 1, 2, 3, 4 or 5.
- Exception entry, EXL=1: only ExcCode is updated. EPC, BD and BadVAddr are unchanged, and offset 0x180 is always used.
- Vector base: BEV ? BEV_BASE : {2'b10, EBase[29:12], 12'b0}.
- Vector offset:
  - Interrupt (code 0) with IV=0: 0x180.
  - Interrupt with IV=1 and VECTORED=0: 0x200.
  - Interrupt with IV=1 and VECTORED=1: 0x200 + n*VEC_SPACING, where n is the highest set bit of IP&IM, using the register state in the entry cycle. If no bit is set, n=0.
  - Any other code: 0x180.
  - All of these apply only while EXL=0.
- ERET: EXL <= 0 and exc_jmp_dest <= EPC. This applies even when EXL is already 0.
- exc_jmp_flag is high for exactly 1 cycle after the posedge that sampled exc_valid or eret. exc_jmp_dest holds its value until the next event.
- Latency: register writes are visible on rd_data in the following cycle; there is no write-to-read bypass.

Test Plan:
- Reset, then read all registers: EBase=32'h80000000, all others 0. Write 32'hFFFFFFFF to Status, then read back 32'h0040FF03.
- Write Compare=10, then Count=5, with COUNT_DIV=1. timer_irq rises once registered Count reaches 10, i.e. 6 clocks after the Count write. With IM[7]=1 and IE=1, int_req=1. Writing Compare clears timer_irq on the next cycle.
- exc_valid with code=4, exc_epc=32'h80001004, exc_bd=1, badvaddr=32'h1234 → EPC=32'h80001000, BD=1, BadVAddr=32'h1234, EXL=1, exc_jmp_dest=32'h80000180, flag high for 1 cycle.
- With EXL=1, exc_valid code=10 → EPC unchanged, ExcCode=10. Then eret → exc_jmp_dest=old EPC, EXL=0.
- IV=1, VECTORED=1, hw_int[1]=1 (IP3), IM=8'hFF, IE=1, code 0 → exc_jmp_dest = 32'h80000000 + 0x200 + 3*32 = 32'h80000260. With BEV=1 → 32'hBFC00200 + 0x260.
- Same cycle: exc_valid=1, eret=1, and a Compare write → exception taken, Compare unchanged, EXL=1. Asserting rst mid-sequence returns all registers to reset values on the next posedge.

Source files
------------

// File: rtl/cp0_ctrl_v2.sv
// Second-generation CP0: Status/Cause/EPC/BadVAddr/Count/Compare/EBase with timer,
// interrupt qualification and exception/ERET redirect generation.
module cp0_ctrl_v2 #(
    parameter int unsigned NR_HW_INT   = 5,
    parameter logic [31:0] EBASE_RESET = 32'h80000000,
    parameter logic [31:0] BEV_BASE    = 32'hBFC00200,
    parameter bit          VECTORED    = 1'b1,
    parameter int unsigned VEC_SPACING = 32,
    parameter int unsigned COUNT_DIV   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rd_addr,
    output logic [31:0]          rd_data,
    input  logic                 wr_en,
    input  logic [4:0]           wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          exc_epc,
    input  logic                 exc_bd,
    input  logic [31:0]          exc_badvaddr,
    input  logic                 eret,
    input  logic [NR_HW_INT-1:0] hw_int,
    output logic                 int_req,
    output logic                 timer_irq,
    output logic                 exc_jmp_flag,
    output logic [31:0]          exc_jmp_dest
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_EBASE    = 5'd15;

    logic [7:0]           im;
    logic                 bev, exl, ie;
    logic                 bd, iv;
    logic [1:0]           ip_sw;
    logic [NR_HW_INT-1:0] ip_hw;
    logic [4:0]           code_q;
    logic                 timer_q;
    logic [31:0]          epc, badvaddr, count, compare;
    logic [17:0]          ebase_f;
    logic [7:0]           prescale;
    logic                 jmp_flag;
    logic [31:0]          jmp_dest;

    logic [7:0]  ip, pending;
    logic [2:0]  irq_num;
    logic [31:0] vec_base, vec_off;
    logic        wr_ok, wr_count, wr_compare;

    assign ip         = {timer_q, 5'(ip_hw), ip_sw};
    assign pending    = ip & im;
    assign wr_ok      = wr_en & ~exc_valid & ~eret;
    assign wr_count   = wr_ok && (wr_addr == REG_COUNT);
    assign wr_compare = wr_ok && (wr_addr == REG_COMPARE);

    // Highest pending line wins the vector slot.
    always_comb begin
        irq_num = '0;
        for (int unsigned i = 0; i < 8; i++)
            if (pending[i]) irq_num = 3'(i);
    end

    always_comb begin
        vec_base = bev ? BEV_BASE : {2'b10, ebase_f, 12'b0};
        vec_off  = 32'h180;
        if (!exl && exc_code == 5'd0 && iv)
            vec_off = VECTORED ? 32'h200 + 32'(irq_num) * 32'(VEC_SPACING) : 32'h200;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im       <= '0;
            bev      <= 1'b0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            iv       <= 1'b0;
            ip_sw    <= '0;
            ip_hw    <= '0;
            code_q   <= '0;
            timer_q  <= 1'b0;
            epc      <= '0;
            badvaddr <= '0;
            count    <= '0;
            compare  <= '0;
            ebase_f  <= EBASE_RESET[29:12];
            prescale <= '0;
            jmp_flag <= 1'b0;
            jmp_dest <= '0;
        end else begin
            ip_hw <= hw_int;

            if (wr_count) begin
                count    <= wr_data;
                prescale <= '0;
            end else if (prescale == 8'(COUNT_DIV - 1)) begin
                count    <= count + 32'd1;
                prescale <= '0;
            end else begin
                prescale <= prescale + 8'd1;
            end

            if (wr_compare)
                timer_q <= 1'b0;
            else if (count == compare)
                timer_q <= 1'b1;

            jmp_flag <= exc_valid | eret;

            if (exc_valid) begin
                code_q   <= exc_code;
                jmp_dest <= vec_base + vec_off;
                if (!exl) begin
                    epc <= exc_bd ? exc_epc - 32'd4 : exc_epc;
                    bd  <= exc_bd;
                    exl <= 1'b1;
                    if (exc_code >= 5'd1 && exc_code <= 5'd5)
                        badvaddr <= exc_badvaddr;
                end
            end else if (eret) begin
                exl      <= 1'b0;
                jmp_dest <= epc;
            end else if (wr_en) begin
                // Count writes are handled with the increment above.
                case (wr_addr)
                    REG_COMPARE: compare <= wr_data;
                    REG_STATUS: begin
                        im  <= wr_data[15:8];
                        bev <= wr_data[22];
                        exl <= wr_data[1];
                        ie  <= wr_data[0];
                    end
                    REG_CAUSE: begin
                        ip_sw <= wr_data[9:8];
                        iv    <= wr_data[23];
                    end
                    REG_EPC:   epc     <= wr_data;
                    REG_EBASE: ebase_f <= wr_data[29:12];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            REG_BADVADDR: rd_data = badvaddr;
            REG_COUNT:    rd_data = count;
            REG_COMPARE:  rd_data = compare;
            REG_STATUS:   rd_data = {9'b0, bev, 6'b0, im, 6'b0, exl, ie};
            REG_CAUSE:    rd_data = {bd, 7'b0, iv, 7'b0, ip, 1'b0, code_q, 2'b0};
            REG_EPC:      rd_data = epc;
            REG_EBASE:    rd_data = {2'b10, ebase_f, 12'b0};
            default:      rd_data = '0;
        endcase
    end

    assign int_req      = ie & ~exl & (|pending);
    assign timer_irq    = timer_q;
    assign exc_jmp_flag = jmp_flag;
    assign exc_jmp_dest = jmp_dest;

endmodule
